acumulador_serie: RTL
=====================

Name: acumulador_serie

Overview:
- Downstream consumer of the 4-bit two's-complement stage.
- Takes the operand that stage produces: the value as-is when summing, or its two's complement when subtracting.
- Adds the operand into a persistent accumulator using a bit-serial adder, one bit per clock, LSB first.
- Exposes result flags and a start/busy/done handshake to the datapath controller.

Parameters:
- N, 4, operand/accumulator width in bits (N >= 2).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request one accumulate operation; sampled only in IDLE.
- clear  input  1  synchronous clear of accumulator and flags; sampled only in IDLE.
- operando  input  N  operand from the complement stage, already sign-adjusted.
- acc  output  N  accumulator value, registered.
- busy  output  1  high while a serial addition is in progress.
- done  output  1  single-cycle pulse: acc and flags have just been updated.
- carry  output  1  carry out of the MSB of the last addition.
- overflow  output  1  signed overflow of the last addition.
- zero  output  1  high when the last result was all zeros.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset (asynchronous, any state):
  - acc=0; carry=overflow=zero=0; busy=0; done=0.
  - State returns to IDLE; internal shift registers, bit counter and serial carry are cleared.
- States: IDLE, SHIFT, FIN.
- IDLE:
  - clear=1 at an edge: acc, carry, overflow and zero go to 0; stay in IDLE. clear has priority over start.
  - start=1 (clear=0) at edge E0:
    - A <= acc, B <= operando, serial carry c <= 0, counter <= 0.
    - Go to SHIFT; busy=1 after E0.
  - Otherwise hold all outputs; done=0.
- SHIFT, on each of edges E1..EN:
  - s = A[0]^B[0]^c; c <= majority(A[0],B[0],c).
  - s is shifted into the result register from the MSB side; A and B shift right; counter++.
  - At the edge processing bit N-1: capture the carry into the MSB (cin_msb) and the carry out (cout), then go to FIN.
- FIN (entered at EN): in the same registered update at EN:
  - acc <= result; carry <= cout; overflow <= cin_msb ^ cout; zero <= (result==0).
  - done=1 and busy=0 for exactly the cycle after EN.
  - The next edge returns to IDLE with done=0.
  - This cycle behaves as IDLE for start/clear: a start here is accepted as a new E0.
- Latency: start sampled at E0; acc and flags valid and done high in the cycle after EN, i.e. N+1 edges after acceptance. Back-to-back throughput is one operation per N+1 cycles.
- start and clear while busy=1 are ignored: no queuing, no effect on the operation in progress.
- operando is captured only at E0. Changes during SHIFT have no effect.
- Arithmetic is modulo 2^N; carry-in is always 0. Subtraction relies entirely on the upstream complement.
- Flags change only at EN (addition) or on clear/reset, and hold otherwise.
- Reset mid-SHIFT: operation aborted, no done pulse, acc=0.

Test Plan:
- Reset asserted asynchronously between edges: acc=0000, carry=overflow=zero=0, busy=0, done=0 immediately, without waiting for a clock edge.
- From acc=0000, operando=0011, start at E0: busy=1 during E1..E3, done=1 after E4 only; acc=0011, carry=0, overflow=0, zero=0.
- Then operando=1101 (-3 from the complement stage), start: acc=0000, carry=1, overflow=0, zero=1.
- Clear, add 0111, then add 0001: acc=1000, overflow=1, carry=0, zero=0. Then add 1000: acc=0000, carry=1, overflow=1, zero=1.
- start pulsed and operando changed to 1111 at E2 of a running add of 0010 from acc=0001: result acc=0011, exactly one done pulse. clear asserted mid-operation is ignored. clear in IDLE gives acc=0000 and all flags 0. start asserted in the done cycle begins a new operation at that edge.
- Reset asserted after E2 of an add of 0101 from acc=0011: acc=0000, no done pulse. After release, start with 0001 gives acc=0001 after N+1 edges.

Source files
------------

// File: rtl/acumulador_serie.sv
// acumulador_serie: bit-serial accumulator, LSB first, one bit per clock.
// Start/busy/done handshake; carry, overflow and zero flags of last add.
module acumulador_serie #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         clear,
    input  logic [N-1:0] operando,
    output logic [N-1:0] acc,
    output logic         busy,
    output logic         done,
    output logic         carry,
    output logic         overflow,
    output logic         zero
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN
    } state_t;

    state_t        state;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [N-1:0]  res;
    logic          c;
    logic [CW-1:0] cnt;

    logic          s;
    logic          cn;
    logic [N-1:0]  sum;

    assign s   = a[0] ^ b[0] ^ c;
    assign cn  = (a[0] & b[0]) | (a[0] & c) | (b[0] & c);
    assign sum = {s, res[N-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            res      <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    done <= 1'b0;
                    if (clear) begin
                        acc      <= '0;
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                        zero     <= 1'b0;
                        state    <= IDLE;
                    end else if (start) begin
                        a     <= acc;
                        b     <= operando;
                        res   <= '0;
                        c     <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    res <= sum;
                    a   <= a >> 1;
                    b   <= b >> 1;
                    c   <= cn;
                    cnt <= cnt + 1'b1;
                    // Last bit: c is the carry into the MSB, cn the carry out
                    if (cnt == LAST) begin
                        acc      <= sum;
                        carry    <= cn;
                        overflow <= c ^ cn;
                        zero     <= (sum == '0);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= FIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
